// File: rtl/prio_enc_rr_pkg.sv
// Shared constants and helpers for the priority encoder / round-robin picker.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int pe_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_rr_if.sv
// Request/selection bundle between requesters and the picker.
interface prio_enc_rr_if
  import prio_enc_pkg::*;
#(
  parameter int N = 8
);

  localparam int W = pe_width(N);

  logic [N-1:0] req;
  logic         mode;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output req, mode, out_ready,
    input  out_idx, out_onehot, out_valid
  );

  modport slave (
    input  req, mode, out_ready,
    output out_idx, out_onehot, out_valid
  );

endinterface

// File: rtl/prio_enc_rr_find.sv
// Highest set bit strictly below ptr, wrapping to N-1 down to ptr.
module prio_find
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = pe_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Upper segment first; any hit below ptr then overrides it.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && i >= int'(ptr)) idx = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && i < int'(ptr)) idx = W'(i);
    end
  end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered fixed-priority / round-robin request picker with valid/ready.
module prio_enc_rr
  import prio_enc_pkg::*;
#(
  parameter int N = 8
) (
  input logic      clk,
  input logic      rst,
  prio_enc_rr_if.slave bus
);

  localparam int W = pe_width(N);

  logic [W-1:0] ptr;
  logic [W-1:0] p_eff;
  logic [W-1:0] p_srch;
  logic         acc;
  logic         load;
  logic         found;
  logic [W-1:0] idx;

  assign acc    = bus.out_valid && bus.out_ready;
  assign load   = !bus.out_valid || bus.out_ready;
  assign p_eff  = acc ? bus.out_idx : ptr;
  // Fixed priority is the wrap search starting from 0.
  assign p_srch = (bus.mode == MODE_RR) ? p_eff : '0;

  prio_find #(.N(N)) u_find (
    .req   (bus.req),
    .ptr   (p_srch),
    .found (found),
    .idx   (idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_idx    <= '0;
      bus.out_onehot <= '0;
      ptr            <= '0;
    end else begin
      if (acc) ptr <= bus.out_idx;
      if (load) begin
        bus.out_valid  <= found;
        bus.out_idx    <= found ? idx : '0;
        bus.out_onehot <= found ? (N'(1) << idx) : '0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed + randomised bench for prio_enc_rr at N=8 and N=5.
module tb_prio_enc_rr;
  import prio_enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  prio_enc_rr_if #(.N(8)) a ();
  prio_enc_rr_if #(.N(5)) b ();

  prio_enc_rr #(.N(8)) u_a (.clk(clk), .rst(rst), .bus(a));
  prio_enc_rr #(.N(5)) u_b (.clk(clk), .rst(rst), .bus(b));

  // reference state: [0] = N8 instance, [1] = N5 instance
  int mv[2];
  int mi[2];
  int mp[2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Search order: P-1, P-2, ... 0, N-1, ... P (rotation modulo n).
  task automatic mstep(input int k, input int n, input logic [63:0] r,
                       input logic md, input logic rdy, input logic rs);
    int p;
    int found;
    int sel;
    int c;
    if (rs) begin
      mv[k] = 0; mi[k] = 0; mp[k] = 0;
      return;
    end
    if (mv[k] != 0 && !rdy) return;
    p = (mv[k] != 0) ? mi[k] : mp[k];
    if (mv[k] != 0) mp[k] = mi[k];
    if (md == MODE_FIXED) p = 0;
    found = 0;
    sel = 0;
    for (int j = 1; j <= n; j++) begin
      c = (p - j + n) % n;
      if (found == 0 && r[c]) begin
        found = 1;
        sel = c;
      end
    end
    mv[k] = found;
    mi[k] = sel;
  endtask

  task automatic tick();
    logic [63:0] one;
    @(posedge clk);
    mstep(0, 8, 64'(a.req), a.mode, a.out_ready, rst);
    mstep(1, 5, 64'(b.req), b.mode, b.out_ready, rst);
    #1;
    one = 64'd1;
    chk("a_valid", 64'(a.out_valid), 64'(mv[0]));
    chk("a_idx", 64'(a.out_idx), 64'(mi[0]));
    chk("a_onehot_model", 64'(a.out_onehot),
        (mv[0] != 0) ? (one << mi[0]) : 64'd0);
    chk("a_onehot_self", 64'(a.out_onehot),
        a.out_valid ? (one << a.out_idx) : 64'd0);
    chk("b_valid", 64'(b.out_valid), 64'(mv[1]));
    chk("b_idx", 64'(b.out_idx), 64'(mi[1]));
    chk("b_onehot_self", 64'(b.out_onehot),
        b.out_valid ? (one << b.out_idx) : 64'd0);
    chk("b_range", 64'(b.out_idx <= 3'd4), 64'd1);
  endtask

  initial begin
    int exp_a[5];
    int exp_b[5];
    exp_a = '{7, 5, 3, 1, 7};
    exp_b = '{4, 0, 4, 0, 4};
    mv = '{0, 0}; mi = '{0, 0}; mp = '{0, 0};
    a.req = '0; a.mode = MODE_FIXED; a.out_ready = 1'b1;
    b.req = '0; b.mode = MODE_FIXED; b.out_ready = 1'b1;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(a.out_valid), 64'd0);
    chk("rst_idx", 64'(a.out_idx), 64'd0);
    chk("rst_onehot", 64'(a.out_onehot), 64'd0);

    // fixed priority, then empty request
    rst = 1'b0;
    a.req = 8'b1010_1010;
    tick();
    chk("fix_idx", 64'(a.out_idx), 64'd7);
    chk("fix_onehot", 64'(a.out_onehot), 64'h80);
    chk("fix_valid", 64'(a.out_valid), 64'd1);
    a.req = '0;
    tick();
    chk("empty_valid", 64'(a.out_valid), 64'd0);
    chk("empty_idx", 64'(a.out_idx), 64'd0);

    // round-robin rotation on both widths
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a.mode = MODE_RR; a.req = 8'b1010_1010; a.out_ready = 1'b1;
    b.mode = MODE_RR; b.req = 5'b10001; b.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr8_%0d", i), 64'(a.out_idx), 64'(exp_a[i]));
      chk($sformatf("rr5_%0d", i), 64'(b.out_idx), 64'(exp_b[i]));
    end

    // stall holds selection despite request change
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a.mode = MODE_FIXED; a.req = 8'h81; a.out_ready = 1'b0;
    tick();
    chk("stall_first", 64'(a.out_idx), 64'd7);
    tick();
    tick();
    chk("stall_idx", 64'(a.out_idx), 64'd7);
    chk("stall_valid", 64'(a.out_valid), 64'd1);
    a.req = 8'h01;
    tick();
    chk("stall_reqchg", 64'(a.out_idx), 64'd7);
    a.out_ready = 1'b1;
    tick();
    chk("stall_release", 64'(a.out_idx), 64'd0);

    // reset discards a stalled selection and clears ptr
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a.mode = MODE_RR; a.req = 8'h20; a.out_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_idx", 64'(a.out_idx), 64'd5);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(a.out_valid), 64'd0);
    chk("mid_rst_idx", 64'(a.out_idx), 64'd0);
    chk("mid_rst_onehot", 64'(a.out_onehot), 64'd0);
    rst = 1'b0;
    a.req = 8'hFF; a.out_ready = 1'b1;
    tick();
    chk("post_rst_idx", 64'(a.out_idx), 64'd7);

    // randomised run against the reference model
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      a.req = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7))
                                          : 8'($urandom);
      b.req = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4))
                                          : 5'($urandom);
      a.out_ready = ($urandom_range(0, 3) != 0);
      b.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) a.mode = 1'($urandom);
      if ($urandom_range(0, 15) == 0) b.mode = 1'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
